// File: rtl/uart_word_tx_if.sv
// ---------------------------------------------------------------------------
// uart_word_tx_if
//
// Bundles the word handshake and the serial-side status of uart_word_tx.
//
// Signals:
//   in_data   word to transmit (WORD_W bits), held by the source until taken
//   in_valid  source has a word ready
//   in_ready  transmitter can take a word (only while idle)
//   uart_txd  serial line, idle high
//   busy      a word is in flight
//   tx_done   one-cycle pulse when the final bit of a word has completed
//
// Modports:
//   master    word source side (drives in_data/in_valid)
//   slave     transmitter side (drives everything else)
// ---------------------------------------------------------------------------
interface uart_word_tx_if #(
    parameter int WORD_W = 64
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              uart_txd;
    logic              busy;
    logic              tx_done;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  uart_txd,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output uart_txd,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/uart_word_tx.sv
// ---------------------------------------------------------------------------
// uart_word_tx
//
// Takes a WORD_W-bit word through a valid/ready handshake and sends it as
// WORD_W/8 back-to-back 8N1 frames, least-significant byte first, bit 0 of
// each byte first. GAP_BITS idle bit-times follow every stop bit, including
// the one of the last byte. tx_done pulses for one cycle as the line returns
// to idle, which is also the first cycle a new word can be accepted.
//
// Parameters:
//   CLK_F     system clock in Hz
//   UART_BPS  baud rate
//   CLK_GOAL  clocks per bit (>= 2)
//   WORD_W    word width, multiple of 8, 8..256
//   GAP_BITS  idle bit-times after every byte, 0..15
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   bus       uart_word_tx_if.slave (in_data, in_valid, in_ready,
//             uart_txd, busy, tx_done)
//
// Optional feature:
//   UART_PARITY_EN  when defined, an even-parity bit follows the data bits
//                   (11-bit frames); otherwise frames are plain 8N1.
// ---------------------------------------------------------------------------
module uart_word_tx #(
    parameter int CLK_F    = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int CLK_GOAL = CLK_F / UART_BPS,
    parameter int WORD_W   = 64,
    parameter int GAP_BITS = 0
) (
    input  logic          clk,
    input  logic          rst,
    uart_word_tx_if.slave bus
);

    localparam int NBYTES = WORD_W / 8;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = (CLK_GOAL > 1) ? $clog2(CLK_GOAL) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_GOAL - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
    localparam logic [3:0]        GAP_LAST  = 4'(GAP_BITS - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, GAP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, GAP
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;
    logic                txd_q, txd_d;
    logic                done_q, done_d;
`ifdef UART_PARITY_EN
    logic                par_q, par_d;
`endif

    logic                baudWrap;
    logic                byteDone;

    // Next-state logic. Every transition happens on the last clock of a
    // bit-time. The shift register moves one bit per data bit-time, so after
    // eight of them the next byte already sits in the low bits. The line
    // level is computed from the next state so uart_txd can be registered.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        done_d     = 1'b0;
        txd_d      = 1'b1;
        byteDone   = 1'b0;
`ifdef UART_PARITY_EN
        par_d      = par_q;
`endif

        baudWrap = (baud_cnt_q == CNT_LAST);
        if (state_q != IDLE) begin
            baud_cnt_d = baudWrap ? '0 : baud_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d    = START;
                    shift_d    = bus.in_data;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            START: begin
                if (baudWrap) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
`ifdef UART_PARITY_EN
                    par_d     = 1'b0;
`endif
                end
            end
            DATA: begin
                if (baudWrap) begin
                    shift_d = shift_q >> 1;
`ifdef UART_PARITY_EN
                    par_d   = par_q ^ shift_q[0];
`endif
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (baudWrap) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baudWrap) begin
                    if (GAP_BITS > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end else begin
                        byteDone = 1'b1;
                    end
                end
            end
            GAP: begin
                if (baudWrap) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        byteDone = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // End of a byte's trailing idle: either start the next byte or
        // finish the word and raise the completion pulse.
        if (byteDone) begin
            if (byte_idx_q == BYTE_LAST) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d    = START;
                byte_idx_d = byte_idx_q + BYTE_W'(1);
            end
        end

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            gap_cnt_q  <= '0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
`ifdef UART_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign bus.uart_txd = txd_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.in_ready = (state_q == IDLE);
    assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_word_tx
//
// Self-checking bench for uart_word_tx with WORD_W=16, GAP_BITS=2,
// CLK_GOAL=4. A reference model turns every accepted word into the list of
// line levels expected on each following clock; a compare process checks
// uart_txd, busy, in_ready and tx_done against it every cycle. A directed
// 16'hA55A word pins the model with hand-derived bit levels and length.
// Honours UART_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uart_word_tx;

    localparam int CLK_GOAL = 4;
    localparam int WORD_W   = 16;
    localparam int GAP_BITS = 2;
    localparam int NBYTES   = WORD_W / 8;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS  = 11;
    localparam int LIT_CYCLES  = 104;
    localparam int LIT_BITS    = 26;
`else
    localparam int FRAME_BITS  = 10;
    localparam int LIT_CYCLES  = 96;
    localparam int LIT_BITS    = 24;
`endif
    localparam int WORD_CYCLES = NBYTES * (FRAME_BITS + GAP_BITS) * CLK_GOAL;
    localparam int WAIT_BOUND  = WORD_CYCLES + 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    uart_word_tx_if #(.WORD_W(WORD_W)) bus ();

    uart_word_tx #(
        .CLK_GOAL (CLK_GOAL),
        .WORD_W   (WORD_W),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected line level for each clock still to come in the current word.
    bit expQ[$];
    bit expDone = 1'b0;
    bit modelOn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Each byte: start 0, eight data bits LSB first, optional even parity,
    // stop 1, then GAP_BITS idle bit-times; each level lasts CLK_GOAL clocks.
    function automatic void pushWord(input logic [WORD_W-1:0] w);
        for (int b = 0; b < NBYTES; b++) begin
            logic [7:0] by;
            by = w[8*b +: 8];
            repeat (CLK_GOAL) expQ.push_back(1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CLK_GOAL) expQ.push_back(by[i]);
            end
`ifdef UART_PARITY_EN
            repeat (CLK_GOAL) expQ.push_back(^by);
`endif
            repeat ((1 + GAP_BITS) * CLK_GOAL) expQ.push_back(1'b1);
        end
    endfunction

    // Advances the model on each edge using the inputs present at that edge,
    // then compares all outputs shortly after the edge.
    always @(posedge clk) begin : compare
        logic              r;
        logic              v;
        logic [WORD_W-1:0] d;
        bit                expBusy;
        bit                expTxd;
        r = rst;
        v = bus.in_valid;
        d = bus.in_data;
        #1;
        if (r) begin
            expQ.delete();
            expDone = 1'b0;
            modelOn = 1'b1;
        end else if (expQ.size() > 0) begin
            void'(expQ.pop_front());
            expDone = (expQ.size() == 0);
        end else begin
            expDone = 1'b0;
            if (v) pushWord(d);
        end
        if (modelOn) begin
            expBusy = (expQ.size() > 0);
            expTxd  = expBusy ? expQ[0] : 1'b1;
            checkOutput("txd",     32'(bus.uart_txd), 32'(expTxd));
            checkOutput("busy",    32'(bus.busy),     32'(expBusy));
            checkOutput("ready",   32'(bus.in_ready), 32'(!expBusy));
            checkOutput("txDone",  32'(bus.tx_done),  32'(expDone));
        end
    end

    task automatic waitDone();
        int n;
        n = 0;
        while (bus.tx_done !== 1'b1 && n < WAIT_BOUND) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneWithinBound", 32'(n < WAIT_BOUND), 32'(1));
    endtask

    // Presents one word after some idle cycles, optionally pokes in_valid
    // again mid-word (which must be ignored), and waits for completion.
    task automatic applyStimulus(input logic [WORD_W-1:0] w, input int idle,
                                 input bit spur);
        repeat (idle) @(negedge clk);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (spur) begin
            repeat ($urandom_range(1, 40)) @(negedge clk);
            checkOutput("readyWhileBusy", 32'(bus.in_ready), 32'(0));
            bus.in_data  = WORD_W'($urandom);
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        waitDone();
    endtask

    initial begin
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        logic [0:25]       expBits;
        bit                trace [128];
        int                n;
        int                doneSeen;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstTxd",   32'(bus.uart_txd), 32'(1));
        checkOutput("rstBusy",  32'(bus.busy),     32'(0));
        checkOutput("rstReady", 32'(bus.in_ready), 32'(1));
        checkOutput("rstDone",  32'(bus.tx_done),  32'(0));
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed word 16'hA55A");
        bus.in_data  = 16'hA55A;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.tx_done !== 1'b1 && n < WAIT_BOUND) begin
            if (n < 128) trace[n] = bus.uart_txd;
            n++;
            @(negedge clk);
        end
        checkOutput("wordLength", 32'(n), 32'(LIT_CYCLES));
`ifdef UART_PARITY_EN
        expBits = 26'b0010110100111_0101001010111;
`else
        expBits = {24'b001011010111_010100101111, 2'b00};
`endif
        for (int i = 0; i < LIT_BITS; i++) begin
            checkOutput($sformatf("litBit%0d", i),
                        32'(trace[i*CLK_GOAL + 1]), 32'(expBits[i]));
        end
        @(negedge clk);
        checkOutput("donePulseOneCycle", 32'(bus.tx_done), 32'(0));

        $display("[TB] back-to-back words with in_valid held");
        w1 = WORD_W'($urandom);
        w2 = WORD_W'($urandom);
        bus.in_data  = w1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        waitDone();
        bus.in_data = w2;
        @(negedge clk);
        checkOutput("b2bStartBit", 32'(bus.uart_txd), 32'(0));
        checkOutput("b2bBusy",     32'(bus.busy),     32'(1));
        bus.in_valid = 1'b0;
        waitDone();

        $display("[TB] in_valid pulse while busy");
        applyStimulus(WORD_W'($urandom), 0, 1'b1);

        $display("[TB] reset mid-word");
        bus.in_data  = WORD_W'($urandom);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstTxd",   32'(bus.uart_txd), 32'(1));
        checkOutput("midRstBusy",  32'(bus.busy),     32'(0));
        checkOutput("midRstReady", 32'(bus.in_ready), 32'(1));
        doneSeen = 0;
        repeat (WORD_CYCLES) begin
            @(negedge clk);
            if (bus.tx_done === 1'b1) doneSeen++;
        end
        checkOutput("noDoneAfterReset", 32'(doneSeen), 32'(0));

        $display("[TB] randomized words");
        for (int k = 0; k < 12; k++) begin
            applyStimulus(WORD_W'($urandom), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
